// File: rtl/gamepad_pkg.sv
// gamepad_pkg
//   Shared definitions for the gamepad PMOD serial link.
//   - gp_state_e  : transmitter FSM states
//   - GP_NUM_BITS : bits per frame (two controllers x 12 buttons)
//   - GP_BTN_*    : button bit index within one 12-bit controller word
//   - gpBitIndex  : position of a button inside the full frame word
//                   (controller 0 occupies the upper half)
package gamepad_pkg;

  localparam int GP_NUM_BITS  = 24;
  localparam int GP_CTRL_BITS = 12;

  localparam int GP_BTN_B      = 11;
  localparam int GP_BTN_Y      = 10;
  localparam int GP_BTN_SELECT = 9;
  localparam int GP_BTN_START  = 8;
  localparam int GP_BTN_UP     = 7;
  localparam int GP_BTN_DOWN   = 6;
  localparam int GP_BTN_LEFT   = 5;
  localparam int GP_BTN_RIGHT  = 4;
  localparam int GP_BTN_A      = 3;
  localparam int GP_BTN_X      = 2;
  localparam int GP_BTN_L      = 1;
  localparam int GP_BTN_R      = 0;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    GAP
  } gp_state_e;

  function automatic int gpBitIndex(input int ctrl, input int btn);
    return (ctrl == 0) ? (GP_CTRL_BITS + btn) : btn;
  endfunction

endpackage

// File: rtl/gamepad_clk_div.sv
// gamepad_clk_div
//   Free-running divider that emits a one-cycle tick every (i_terminal+1)
//   system clocks. The transmitter uses it for both pmod_clk half-periods
//   and the inter-frame gap, so the terminal count is a run-time input.
// Ports
//   i_clk      : system clock
//   i_rst_n    : synchronous active-low reset
//   i_clear    : hold the count at zero (no tick while asserted)
//   i_terminal : count value on which the tick fires
//   o_tick     : one-cycle pulse at the end of each period
module gamepad_clk_div
  import gamepad_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_terminal,
  output logic             o_tick
);

  logic [WIDTH-1:0] r_cnt;
  logic             w_at_end;

  assign w_at_end = (r_cnt == i_terminal);
  assign o_tick   = w_at_end & ~i_clear;

  // The count restarts from zero on every tick, so a change of terminal
  // value takes effect cleanly at the start of the next period.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || w_at_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gamepad_pmod_tx.sv
// gamepad_pmod_tx
//   Transmit end of the gamepad PMOD link. Accepts a 24-bit button word on a
//   valid/ready handshake and bit-bangs it MSB first on pmod_clk/pmod_data,
//   followed by a latch pulse and an idle gap.
// Ports
//   i_clk          : system clock
//   i_rst_n        : synchronous active-low reset
//   i_btn_data     : button word, [23:12] controller 0, [11:0] controller 1
//   i_btn_valid    : i_btn_data valid
//   o_btn_ready    : word accepted this cycle when valid is also high
//   o_pmod_clk     : serial clock, receiver samples data on its rising edge
//   o_pmod_latch   : frame-end latch pulse, active high
//   o_pmod_data    : serial data, MSB first
//   o_busy         : frame in progress
// Configuration
//   GAMEPAD_TX_REPEAT_EN : when defined, the last accepted word is kept and
//   retransmitted automatically whenever the block is idle with no new word.
module gamepad_pmod_tx
  import gamepad_pkg::*;
#(
  parameter int CLK_DIV  = 8,
  parameter int NUM_BITS = GP_NUM_BITS,
  parameter int IDLE_GAP = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_BITS-1:0] i_btn_data,
  input  logic                i_btn_valid,
  output logic                o_btn_ready,
  output logic                o_pmod_clk,
  output logic                o_pmod_latch,
  output logic                o_pmod_data,
  output logic                o_busy
);

  localparam int DIV_W = $clog2(CLK_DIV * IDLE_GAP) + 1;
  localparam int BIT_W = $clog2(NUM_BITS);

  localparam logic [DIV_W-1:0] HALF_TERM = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_TERM  = DIV_W'(CLK_DIV * IDLE_GAP - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(NUM_BITS - 1);

  gp_state_e           r_state;
  logic [NUM_BITS-1:0] r_shreg;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic                r_pmod_clk;
  logic                r_pmod_latch;
  logic                r_pmod_data;
  logic                r_busy;

  gp_state_e           w_state_next;
  logic [NUM_BITS-1:0] w_shreg_next;
  logic [BIT_W-1:0]    w_bit_cnt_next;
  logic                w_data_next;
  logic                w_start;
  logic [NUM_BITS-1:0] w_start_word;
  logic                w_clear;
  logic [DIV_W-1:0]    w_terminal;
  logic                w_tick;

  // Divider is held at zero while idle so the first half-period after an
  // accept is a full CLK_DIV cycles; the gap uses a longer terminal count.
  assign w_clear    = (r_state == IDLE);
  assign w_terminal = (r_state == GAP) ? GAP_TERM : HALF_TERM;

  gamepad_clk_div #(
    .WIDTH (DIV_W)
  ) u_clk_div (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (w_clear),
    .i_terminal (w_terminal),
    .o_tick     (w_tick)
  );

  assign o_btn_ready = (r_state == IDLE) & i_rst_n;

`ifdef GAMEPAD_TX_REPEAT_EN
  logic [NUM_BITS-1:0] r_hold;
  logic                r_hold_vld;

  // A fresh word always wins over the held one; the hold register only
  // becomes eligible for replay once something has been accepted.
  assign w_start      = (r_state == IDLE) && (i_btn_valid || r_hold_vld);
  assign w_start_word = i_btn_valid ? i_btn_data : r_hold;

  // Capture every externally accepted word for later retransmission.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
    end else if ((r_state == IDLE) && i_btn_valid) begin
      r_hold     <= i_btn_data;
      r_hold_vld <= 1'b1;
    end
  end
`else
  assign w_start      = (r_state == IDLE) && i_btn_valid;
  assign w_start_word = i_btn_data;
`endif

  // Next-state logic. Data only moves at the SHIFT_HI -> SHIFT_LO boundary,
  // i.e. on the same edge pmod_clk falls, so it is stable while clock is high.
  always_comb begin
    w_state_next   = r_state;
    w_shreg_next   = r_shreg;
    w_bit_cnt_next = r_bit_cnt;
    w_data_next    = r_pmod_data;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_next   = SHIFT_LO;
          w_shreg_next   = w_start_word;
          w_bit_cnt_next = LAST_BIT;
          w_data_next    = w_start_word[NUM_BITS-1];
        end
      end
      SHIFT_LO: begin
        if (w_tick) begin
          w_state_next = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (w_tick) begin
          if (r_bit_cnt == '0) begin
            w_state_next = LATCH;
          end else begin
            w_state_next   = SHIFT_LO;
            w_shreg_next   = r_shreg << 1;
            w_data_next    = r_shreg[NUM_BITS-2];
            w_bit_cnt_next = r_bit_cnt - 1'b1;
          end
        end
      end
      LATCH: begin
        if (w_tick) begin
          w_state_next = GAP;
          w_data_next  = 1'b0;
        end
      end
      GAP: begin
        if (w_tick) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_data_next  = 1'b0;
      end
    endcase
  end

  // Pin outputs are registered from the next state so they change on the
  // same edge as the state itself and never glitch.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_pmod_clk   <= 1'b0;
      r_pmod_latch <= 1'b0;
      r_pmod_data  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_shreg      <= w_shreg_next;
      r_bit_cnt    <= w_bit_cnt_next;
      r_pmod_clk   <= (w_state_next == SHIFT_HI);
      r_pmod_latch <= (w_state_next == LATCH);
      r_pmod_data  <= w_data_next;
      r_busy       <= (w_state_next != IDLE);
    end
  end

  assign o_pmod_clk   = r_pmod_clk;
  assign o_pmod_latch = r_pmod_latch;
  assign o_pmod_data  = r_pmod_data;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_gamepad_pmod_tx.sv
// tb_gamepad_pmod_tx
//   Directed bench for gamepad_pmod_tx. A receiver model captures pmod_data
//   on each rising pmod_clk and counts latch pulses; a second instance with
//   CLK_DIV=2 covers the fastest divider setting.
module tb_gamepad_pmod_tx;

  logic        clk = 1'b0;
  logic        rstN;
  logic [23:0] btnData;
  logic        btnValid;
  logic        ready, pclk, platch, pdata, busy;
  logic [23:0] btnData2;
  logic        btnValid2;
  logic        ready2, pclk2, platch2, pdata2, busy2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acceptCyc = 0;

  always #5 clk = ~clk;

  gamepad_pmod_tx dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_btn_data   (btnData),
    .i_btn_valid  (btnValid),
    .o_btn_ready  (ready),
    .o_pmod_clk   (pclk),
    .o_pmod_latch (platch),
    .o_pmod_data  (pdata),
    .o_busy       (busy)
  );

  gamepad_pmod_tx #(
    .CLK_DIV  (2),
    .NUM_BITS (24),
    .IDLE_GAP (4)
  ) dut2 (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_btn_data   (btnData2),
    .i_btn_valid  (btnValid2),
    .o_btn_ready  (ready2),
    .o_pmod_clk   (pclk2),
    .o_pmod_latch (platch2),
    .o_pmod_data  (pdata2),
    .o_busy       (busy2)
  );

  // Receiver model for the default instance
  logic        pclkPrev = 1'b0, latchPrev = 1'b0, pdataPrev = 1'b0;
  logic [23:0] rxWord = '0;
  int rxCount = 0, latchPulses = 0, latchLen = 0, lastLatchLen = 0, dataViol = 0;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    pclkPrev  <= pclk;
    latchPrev <= platch;
    pdataPrev <= pdata;
    if (pclk && !pclkPrev) begin
      rxWord  <= {rxWord[22:0], pdata};
      rxCount <= rxCount + 1;
    end
    if (platch && !latchPrev) latchPulses <= latchPulses + 1;
    if (platch) latchLen <= latchLen + 1;
    else if (latchPrev) begin
      lastLatchLen <= latchLen;
      latchLen     <= 0;
    end
    if (pclk && pclkPrev && (pdata !== pdataPrev)) dataViol <= dataViol + 1;
  end

  // Receiver model for the CLK_DIV=2 instance
  logic        pclk2Prev = 1'b0;
  logic [23:0] rxWord2 = '0;
  int rxCount2 = 0, highLen2 = 0, lastHigh2 = 0;

  always @(posedge clk) begin
    pclk2Prev <= pclk2;
    if (pclk2 && !pclk2Prev) begin
      rxWord2  <= {rxWord2[22:0], pdata2};
      rxCount2 <= rxCount2 + 1;
    end
    if (pclk2) highLen2 <= highLen2 + 1;
    else if (pclk2Prev) begin
      lastHigh2 <= highLen2;
      highLen2  <= 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Waits for ready, presents one word for exactly one accepting edge.
  task automatic applyStimulus(input logic [23:0] word);
    int n = 0;
    while (!ready && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("ready_before_send", {31'd0, ready}, 32'd1);
    btnData  = word;
    btnValid = 1'b1;
    @(posedge clk); #1;
    acceptCyc = cyc;
    btnValid  = 1'b0;
  endtask

  task automatic waitReady(input string tag, output int elapsed);
    int n = 0;
    while (!ready && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    if (!ready) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    elapsed = cyc - acceptCyc;
  endtask

  initial begin
    int bad, elapsed, baseRx, baseL, n, acc2, baseRx2;
    rstN      = 1'b0;
    btnData   = '0;
    btnValid  = 1'b0;
    btnData2  = '0;
    btnValid2 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", {31'd0, ready}, 32'd0);
    checkOutput("rst_pclk", {31'd0, pclk}, 32'd0);
    checkOutput("rst_latch", {31'd0, platch}, 32'd0);
    checkOutput("rst_data", {31'd0, pdata}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    rstN = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready_after_release", {31'd0, ready}, 32'd1);

`ifndef GAMEPAD_TX_REPEAT_EN
    // Idle for 1000 cycles with nothing offered
    bad = 0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (pclk || platch || pdata || busy || !ready) bad++;
    end
    checkOutput("idle_quiet", bad, 0);

    // Single frame, input changed after accept
    baseRx = rxCount;
    baseL  = latchPulses;
    applyStimulus(24'hA53C81);
    checkOutput("busy_after_accept", {31'd0, busy}, 32'd1);
    btnData = 24'h000000;
    waitReady("frame1", elapsed);
    checkOutput("frame1_len", elapsed, 424);
    checkOutput("frame1_bits", rxCount - baseRx, 24);
    checkOutput("frame1_word", {8'd0, rxWord}, 32'h00A53C81);
    checkOutput("frame1_latches", latchPulses - baseL, 1);
    checkOutput("frame1_latch_len", lastLatchLen, 8);
    checkOutput("frame1_data_stable", dataViol, 0);

    // New word offered while a frame is in flight
    baseRx = rxCount;
    baseL  = latchPulses;
    applyStimulus(24'h00F00F);
    repeat (20) @(posedge clk);
    #1;
    btnData  = 24'hFFFFFF;
    btnValid = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready_low_midframe", {31'd0, ready}, 32'd0);
    waitReady("frame2", elapsed);
    checkOutput("frame2_len", elapsed, 424);
    checkOutput("frame2_word", {8'd0, rxWord}, 32'h0000F00F);
    checkOutput("frame2_bits", rxCount - baseRx, 24);
    @(posedge clk); #1;
    acceptCyc = cyc;
    btnValid  = 1'b0;
    checkOutput("held_word_accepted", {31'd0, busy}, 32'd1);
    waitReady("frame3", elapsed);
    checkOutput("frame3_len", elapsed, 424);
    checkOutput("frame3_word", {8'd0, rxWord}, 32'h00FFFFFF);
    checkOutput("frame23_latches", latchPulses - baseL, 2);

    // Reset in the middle of a frame
    baseRx = rxCount;
    baseL  = latchPulses;
    applyStimulus(24'h0F0F0F);
    n = 0;
    while ((rxCount - baseRx) < 10 && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("reached_bit10", rxCount - baseRx, 10);
    rstN = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_pclk", {31'd0, pclk}, 32'd0);
    checkOutput("midrst_latch", {31'd0, platch}, 32'd0);
    checkOutput("midrst_data", {31'd0, pdata}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_ready", {31'd0, ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    checkOutput("midrst_no_latch", latchPulses - baseL, 0);
    checkOutput("midrst_no_more_bits", rxCount - baseRx, 10);
    baseRx = rxCount;
    applyStimulus(24'h3C3C3C);
    waitReady("frame4", elapsed);
    checkOutput("frame4_len", elapsed, 424);
    checkOutput("frame4_word", {8'd0, rxWord}, 32'h003C3C3C);
    checkOutput("frame4_bits", rxCount - baseRx, 24);
    checkOutput("frame4_latches", latchPulses - baseL, 1);

    // Fastest divider: (2*24+1+4)*2 = 106 cycles per frame
    checkOutput("dut2_ready_idle", {31'd0, ready2}, 32'd1);
    baseRx2   = rxCount2;
    btnData2  = 24'h000001;
    btnValid2 = 1'b1;
    @(posedge clk); #1;
    acc2      = cyc;
    btnValid2 = 1'b0;
    n = 0;
    while (!ready2 && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("dut2_frame_len", cyc - acc2, 106);
    checkOutput("dut2_word", {8'd0, rxWord2}, 32'h00000001);
    checkOutput("dut2_bits", rxCount2 - baseRx2, 24);
    checkOutput("dut2_half_period", lastHigh2, 2);
`else
    // No replay before anything has been accepted
    bad = 0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (busy || pclk || platch) bad++;
    end
    checkOutput("rep_idle_quiet", bad, 0);

    // One accepted word is replayed back-to-back
    baseL = latchPulses;
    applyStimulus(24'h123456);
    waitReady("rep_first", elapsed);
    checkOutput("rep_first_len", elapsed, 424);
    checkOutput("rep_first_word", {8'd0, rxWord}, 32'h00123456);
    @(posedge clk); #1;
    checkOutput("rep_autostart", {31'd0, busy}, 32'd1);
    n = 0;
    while ((latchPulses - baseL) < 3 && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("rep_latches", latchPulses - baseL, 3);
    checkOutput("rep_word", {8'd0, rxWord}, 32'h00123456);

    // A new word replaces the held one
    btnData  = 24'h654321;
    btnValid = 1'b1;
    n = 0;
    while (!ready && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("rep_ready_seen", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    acceptCyc = cyc;
    btnValid  = 1'b0;
    waitReady("rep_new", elapsed);
    checkOutput("rep_new_len", elapsed, 424);
    checkOutput("rep_new_word", {8'd0, rxWord}, 32'h00654321);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
